// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection beside the ID stage. Per-register countdowns track real producer latency
// and drive the PC, IF/ID and ID/EX-bubble controls. A saturating counter records stall cycles.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MUL_LAT      = 3,
    parameter int MUL_OCC      = 2,
    parameter int BRANCH_EXTRA = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ID_Valid,
    input  logic                   ID_Flush,
    input  logic                   ID_IsBranch,
    input  logic                   ID_UsesRS,
    input  logic                   ID_UsesRT,
    input  logic [REG_W-1:0]       ID_RegRS,
    input  logic [REG_W-1:0]       ID_RegRT,
    input  logic                   ID_RegW,
    input  logic [REG_W-1:0]       ID_RegDst,
    input  logic [1:0]             ID_LatClass,
    output logic                   PCWriteSel,
    output logic                   IF_WriteSel_ID,
    output logic                   ControlNopSel,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int LAT_W  = $clog2(MUL_LAT + BRANCH_EXTRA + 1);
    localparam int BUSY_W = (MUL_OCC > 0) ? $clog2(MUL_OCC + 1) : 1;

    localparam logic [LAT_W-1:0]  L_ALU  = LAT_W'(BRANCH_EXTRA);
    localparam logic [LAT_W-1:0]  L_LOAD = LAT_W'(LOAD_LAT + BRANCH_EXTRA);
    localparam logic [LAT_W-1:0]  L_MUL  = LAT_W'(MUL_LAT + BRANCH_EXTRA);
    localparam logic [BUSY_W-1:0] OCC    = BUSY_W'(MUL_OCC);

    logic [LAT_W-1:0]       r_cnt [NUM_REGS];
    logic [BUSY_W-1:0]      r_mul_busy;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic             w_is_mul;
    logic [LAT_W-1:0] w_lat;
    logic [LAT_W-1:0] w_thr;
    logic             w_rs_act;
    logic             w_rt_act;
    logic             w_dst_act;
    logic             w_raw;
    logic             w_waw;
    logic             w_struct;
    logic             w_live;
    logic             w_stall;
    logic             w_issue;

    assign w_is_mul = ID_LatClass[1];
    assign w_lat    = w_is_mul ? L_MUL : (ID_LatClass[0] ? L_LOAD : L_ALU);

    // Branches read operands in ID, so they must wait the extra cycles an EX consumer can skip.
    assign w_thr = ID_IsBranch ? '0 : L_ALU;

    assign w_rs_act  = ID_UsesRS && (ID_RegRS != '0) && (int'(ID_RegRS) < NUM_REGS);
    assign w_rt_act  = ID_UsesRT && (ID_RegRT != '0) && (int'(ID_RegRT) < NUM_REGS);
    assign w_dst_act = ID_RegW && (ID_RegDst != '0) && (int'(ID_RegDst) < NUM_REGS);

    assign w_raw    = (w_rs_act && (r_cnt[ID_RegRS] > w_thr)) ||
                      (w_rt_act && (r_cnt[ID_RegRT] > w_thr));
    assign w_waw    = w_dst_act && (r_cnt[ID_RegDst] > w_lat);
    assign w_struct = w_is_mul && (r_mul_busy != '0);

    assign w_live  = ID_Valid && !ID_Flush;
    assign w_stall = w_live && (w_raw || w_waw || w_struct) && !Reset;
    assign w_issue = w_live && !w_stall;

    assign PCWriteSel     = !w_stall;
    assign IF_WriteSel_ID = !w_stall;
    assign ControlNopSel  = w_stall;
    assign StallCount     = r_stall_count;

    // NOTE: nonblocking assignments in sequential blocks so every entry updates from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: the scoreboard array is real pipeline state, so every entry is reset, unlike a data RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_mul_busy    <= '0;
            r_stall_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i != 0 && w_issue && w_dst_act && int'(ID_RegDst) == i) begin
                    r_cnt[i] <= w_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end

            if (w_issue && w_is_mul) begin
                r_mul_busy <= OCC;
            end else if (r_mul_busy != '0) begin
                r_mul_busy <= r_mul_busy - 1'b1;
            end

            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: directed latency cases plus randomized traffic,
// checked every cycle against a ready-time model of register and multiplier availability.
module tb_hazard_scoreboard_unit;

    localparam int NR  = 32;
    localparam int RW  = 5;
    localparam int LL  = 1;
    localparam int ML  = 3;
    localparam int MO  = 2;
    localparam int BE  = 1;
    localparam int SCW = 16;

    typedef struct packed {
        logic          valid;
        logic          flush;
        logic          br;
        logic          urs;
        logic          urt;
        logic          w;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dst;
        logic [1:0]    cls;
    } instr_t;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           ID_Valid = 1'b0, ID_Flush = 1'b0, ID_IsBranch = 1'b0;
    logic           ID_UsesRS = 1'b0, ID_UsesRT = 1'b0, ID_RegW = 1'b0;
    logic [RW-1:0]  ID_RegRS = '0, ID_RegRT = '0, ID_RegDst = '0;
    logic [1:0]     ID_LatClass = '0;
    logic           PCWriteSel, IF_WriteSel_ID, ControlNopSel;
    logic [SCW-1:0] StallCount;

    hazard_scoreboard_unit #(
        .NUM_REGS(NR), .REG_W(RW), .LOAD_LAT(LL), .MUL_LAT(ML), .MUL_OCC(MO),
        .BRANCH_EXTRA(BE), .STALL_CNT_W(SCW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Flush(ID_Flush),
        .ID_IsBranch(ID_IsBranch), .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT),
        .ID_RegRS(ID_RegRS), .ID_RegRT(ID_RegRT), .ID_RegW(ID_RegW),
        .ID_RegDst(ID_RegDst), .ID_LatClass(ID_LatClass),
        .PCWriteSel(PCWriteSel), .IF_WriteSel_ID(IF_WriteSel_ID),
        .ControlNopSel(ControlNopSel), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute cycle at which each register / the multiplier becomes free.
    longint      t = 0;
    longint      ready [NR];
    longint      mul_free = 0;
    int unsigned m_cnt = 0;
    logic [18:0] exp_q [$];
    bit          mon_en = 1'b0;

    function automatic longint remaining(input longint x);
        return (x > t) ? x - t : 0;
    endfunction

    function automatic int lat_of(input logic [1:0] c);
        if (c == 2'd0) return BE;
        if (c == 2'd1) return LL + BE;
        return ML + BE;
    endfunction

    function automatic bit model_stall(input instr_t i);
        int  thr;
        bit  h;
        if (!i.valid || i.flush) return 1'b0;
        thr = i.br ? 0 : BE;
        h = 1'b0;
        if (i.urs && i.rs != 0 && remaining(ready[i.rs]) > thr) h = 1'b1;
        if (i.urt && i.rt != 0 && remaining(ready[i.rt]) > thr) h = 1'b1;
        if (i.w && i.dst != 0 && remaining(ready[i.dst]) > lat_of(i.cls)) h = 1'b1;
        if (i.cls >= 2 && remaining(mul_free) > 0) h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) ready[r] = 0;
        mul_free = 0;
        m_cnt = 0;
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle: no expected entry queued at %0t", $time);
            end else begin
                check("cycle", {PCWriteSel, IF_WriteSel_ID, ControlNopSel, StallCount},
                      exp_q.pop_front());
            end
        end
    end

    task automatic step(input instr_t i, input bit rst, output bit dut_stall, output bit mdl_stall);
        bit          s;
        logic [18:0] e;
        @(posedge Clk);
        #1;
        Reset       = rst;
        ID_Valid    = i.valid;
        ID_Flush    = i.flush;
        ID_IsBranch = i.br;
        ID_UsesRS   = i.urs;
        ID_UsesRT   = i.urt;
        ID_RegRS    = i.rs;
        ID_RegRT    = i.rt;
        ID_RegW     = i.w;
        ID_RegDst   = i.dst;
        ID_LatClass = i.cls;
        s = 1'b0;
        if (rst) begin
            model_reset();
            e = {3'b110, 16'd0};
        end else begin
            s = model_stall(i);
            e = {~s, ~s, s, m_cnt[15:0]};
            if (s && m_cnt < 32'hFFFF) m_cnt++;
            if (i.valid && !i.flush && !s) begin
                if (i.w && i.dst != 0) ready[i.dst] = t + 1 + lat_of(i.cls);
                if (i.cls >= 2) mul_free = t + 1 + MO;
            end
        end
        exp_q.push_back(e);
        t++;
        #1;
        dut_stall = ControlNopSel;
        mdl_stall = s;
    endtask

    function automatic instr_t mk(input bit br, input bit urs, input int rs, input bit urt,
                                  input int rt, input bit w, input int dst, input int cls);
        instr_t i;
        i.valid = 1'b1;
        i.flush = 1'b0;
        i.br    = br;
        i.urs   = urs;
        i.rs    = RW'(rs);
        i.urt   = urt;
        i.rt    = RW'(rt);
        i.w     = w;
        i.dst   = RW'(dst);
        i.cls   = 2'(cls);
        return i;
    endfunction

    function automatic instr_t alu(input int d, input int s1, input int s2);
        return mk(1'b0, 1'b1, s1, 1'b1, s2, 1'b1, d, 0);
    endfunction
    function automatic instr_t ld(input int d, input int b);
        return mk(1'b0, 1'b1, b, 1'b0, 0, 1'b1, d, 1);
    endfunction
    function automatic instr_t mul(input int d, input int s1, input int s2);
        return mk(1'b0, 1'b1, s1, 1'b1, s2, 1'b1, d, 2);
    endfunction
    function automatic instr_t beq(input int s1, input int s2);
        return mk(1'b1, 1'b1, s1, 1'b1, s2, 1'b0, 0, 0);
    endfunction

    function automatic int pick_reg();
        return ($urandom_range(3) == 0) ? int'($urandom_range(NR - 1)) : int'($urandom_range(4));
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = ($urandom_range(7) != 0);
        i.flush = ($urandom_range(9) == 0);
        i.br    = ($urandom_range(3) == 0);
        i.urs   = $urandom_range(1);
        i.urt   = $urandom_range(1);
        i.rs    = RW'(pick_reg());
        i.rt    = RW'(pick_reg());
        i.w     = $urandom_range(1);
        i.dst   = RW'(pick_reg());
        i.cls   = 2'($urandom_range(3));
        return i;
    endfunction

    task automatic drain();
        bit ds, ms;
        repeat (6) step('0, 1'b0, ds, ms);
    endtask

    // Producer issues, then the consumer is held until the DUT stops stalling it.
    task automatic pair(input string name, input instr_t p, input instr_t c, input int exp_n);
        bit ds, ms;
        int n;
        bit done;
        drain();
        step(p, 1'b0, ds, ms);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(c, 1'b0, ds, ms);
            if (ds) n++;
            else done = 1'b1;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        bit     ds, ms, hold;
        instr_t cur, fl;
        int     n_st;

        model_reset();
        mon_en = 1'b1;
        repeat (3) step('0, 1'b1, ds, ms);

        step('0, 1'b0, ds, ms);
        check("idle_outputs", {PCWriteSel, IF_WriteSel_ID, ControlNopSel}, 3'b110);
        check("idle_stallcount", StallCount, 0);

        pair("load_alu", ld(8, 1), alu(12, 8, 0), 1);
        check("stallcount_after_load_alu", StallCount, 1);
        pair("load_branch", ld(8, 1), beq(8, 0), 2);
        pair("alu_branch", alu(9, 1, 2), beq(9, 0), 1);
        pair("alu_alu", alu(9, 1, 2), alu(12, 9, 0), 0);
        pair("mul_alu", mul(10, 1, 2), alu(12, 10, 0), 3);
        pair("mul_branch", mul(10, 1, 2), beq(0, 10), 4);
        pair("mul_mul_struct", mul(10, 1, 2), mul(11, 3, 4), 2);
        pair("mul_waw", mul(10, 1, 2), mk(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 10, 0), 3);
        pair("reg0_alu_branch", alu(0, 1, 2), beq(0, 0), 0);
        pair("reg0_load_alu", ld(0, 1), alu(12, 0, 0), 0);

        // Flushed hazard neither stalls nor loads the scoreboard.
        drain();
        step(ld(8, 1), 1'b0, ds, ms);
        fl = alu(13, 8, 8);
        fl.flush = 1'b1;
        step(fl, 1'b0, ds, ms);
        check("flush_no_stall", ds, 0);
        step(beq(13, 0), 1'b0, ds, ms);
        check("flush_no_load", ds, 0);

        // Asynchronous reset pulse in the middle of a load-use stall.
        drain();
        step(ld(8, 1), 1'b0, ds, ms);
        step(alu(12, 8, 0), 1'b0, ds, ms);
        check("pre_reset_stall", ds, 1);
        #5;
        Reset = 1'b1;
        ID_Valid = 1'b0;
        #1;
        check("async_reset_outputs", {PCWriteSel, IF_WriteSel_ID, ControlNopSel}, 3'b110);
        check("async_reset_stallcount", StallCount, 0);
        #1;
        Reset = 1'b0;
        model_reset();
        step(alu(12, 8, 0), 1'b0, ds, ms);
        check("post_reset_no_stall", ds, 0);

        // Randomized traffic: a stalled instruction is re-presented until it issues or is squashed.
        hold = 1'b0;
        cur = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!hold) cur = rand_instr();
            else cur.flush = ($urandom_range(7) == 0);
            step(cur, ($urandom_range(499) == 0), ds, ms);
            hold = ms;
        end

        // Saturation: a self-dependent multiply-branch stalls four cycles out of five.
        cur = mk(1'b1, 1'b1, 20, 1'b0, 0, 1'b1, 20, 2);
        n_st = 0;
        for (int k = 0; k < 90000 && n_st < 65541; k++) begin
            step(cur, 1'b0, ds, ms);
            if (ds) n_st++;
        end
        check("saturation_stall_cycles", n_st, 65541);
        check("saturation_value", StallCount, 16'hFFFF);

        @(negedge Clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
